// File: rtl/hamming_deframe_decoder_if.sv
// Serial payload input and decoded-bit FIFO write port of hamming_deframe_decoder.
// The slave modport is the decoder's view; master is the producer/FIFO side.
interface hamming_deframe_decoder_if;
    logic DATA_IN;
    logic DATA_IN_VALID;
    logic LOCK;
    logic FIFO_OUT_DATA;
    logic FIFO_OUT_WE;
    logic FIFO_OUT_FULL;

    modport slave (
        input  DATA_IN,
        input  DATA_IN_VALID,
        input  LOCK,
        input  FIFO_OUT_FULL,
        output FIFO_OUT_DATA,
        output FIFO_OUT_WE
    );

    modport master (
        output DATA_IN,
        output DATA_IN_VALID,
        output LOCK,
        output FIFO_OUT_FULL,
        input  FIFO_OUT_DATA,
        input  FIFO_OUT_WE
    );
endinterface

// File: rtl/hamming_deframe_decoder.sv
// Serial Hamming(7,4) decoder: aligns codewords to the deframed payload, corrects
// single-bit errors and streams the 4 data bits per codeword into a sync FIFO.
module hamming_deframe_decoder #(
    parameter int PAYLOAD_LEN = 28,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    hamming_deframe_decoder_if.slave   bus,
    output logic                       CORR_PULSE,
    output logic                       OVERFLOW,
    output logic [CNT_WIDTH-1:0]       ERR_COUNT,
    output logic [CNT_WIDTH-1:0]       DROP_COUNT
);
    localparam int PW = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam logic [PW-1:0]        PAY_LAST = PW'(PAYLOAD_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    if (PAYLOAD_LEN % 7 != 0) begin : g_bad_payload_len
        $error("PAYLOAD_LEN must be a multiple of 7");
    end

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    // cw[0] is c1 (first bit on the line); result is {s3,s2,s1}
    function automatic logic [2:0] syndrome(input logic [6:0] cw);
        syndrome = {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
                    cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
                    cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
    endfunction

    function automatic logic [3:0] correct(input logic [6:0] cw, input logic [2:0] s);
        logic [6:0] fixed;
        if (s != 3'd0) begin
            fixed = cw ^ (7'd1 << (s - 3'd1));
        end else begin
            fixed = cw;
        end
        correct = {fixed[2], fixed[4], fixed[5], fixed[6]};
    endfunction

    logic                 lock_q,  lock_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [PW-1:0]        pay_idx_q, pay_idx_d;
    logic [5:0]           cw_q,    cw_d;
    state_t               state_q, state_d;
    logic [1:0]           ptr_q,   ptr_d;
    logic [1:0]           cnt_q,   cnt_d;
    logic [3:0]           mem0_q,  mem0_d;
    logic [3:0]           mem1_q,  mem1_d;
    logic                 we_q,    we_d;
    logic                 data_q,  data_d;
    logic                 corr_q,  corr_d;
    logic                 ovf_q,   ovf_d;
    logic [CNT_WIDTH-1:0] err_q,   err_d;
    logic [CNT_WIDTH-1:0] drop_q,  drop_d;

    logic          accept_s, realign_s, push_s, pop_s, drop_s;
    logic [2:0]    bit_base_s, syn_s;
    logic [PW-1:0] pay_base_s;
    logic [3:0]    nib_s;
    logic [1:0]    cnt_ap_s;

    // Capture, alignment and single-error correction of the incoming codeword
    always_comb begin
        lock_d     = bus.LOCK;
        accept_s   = bus.DATA_IN_VALID & bus.LOCK;
        realign_s  = ~bus.LOCK | ~lock_q;
        bit_base_s = realign_s ? 3'd0 : bit_idx_q;
        pay_base_s = realign_s ? '0 : pay_idx_q;
        syn_s      = syndrome({bus.DATA_IN, cw_q});
        nib_s      = correct({bus.DATA_IN, cw_q}, syn_s);
        push_s     = accept_s & (bit_base_s == 3'd6);
        cw_d       = cw_q;
        bit_idx_d  = bit_base_s;
        pay_idx_d  = pay_base_s;
        if (accept_s) begin
            if (bit_base_s != 3'd6) begin
                cw_d[bit_base_s] = bus.DATA_IN;
            end else begin
                cw_d = cw_q;
            end
            if (pay_base_s == PAY_LAST) begin
                bit_idx_d = 3'd0;
                pay_idx_d = '0;
            end else begin
                bit_idx_d = (bit_base_s == 3'd6) ? 3'd0 : bit_base_s + 3'd1;
                pay_idx_d = pay_base_s + PW'(1);
            end
        end else begin
            cw_d = cw_q;
        end
    end

    // Nibble queue, status counters and output FSM; a pop frees a slot for a same-cycle push
    always_comb begin
        pop_s    = (state_q == SEND) & ~bus.FIFO_OUT_FULL & (ptr_q == 2'd3);
        drop_s   = push_s & (cnt_q == 2'd2) & ~pop_s;
        cnt_ap_s = cnt_q - {1'b0, pop_s};
        mem0_d   = pop_s ? mem1_q : mem0_q;
        mem1_d   = mem1_q;
        if (push_s && !drop_s) begin
            case (cnt_ap_s)
                2'd0:    mem0_d = nib_s;
                2'd1:    mem1_d = nib_s;
                default: mem1_d = mem1_q;
            endcase
        end else begin
            mem1_d = mem1_q;
        end
        cnt_d  = cnt_ap_s + {1'b0, (push_s & ~drop_s)};

        corr_d = push_s & (syn_s != 3'd0);
        err_d  = (corr_d && (err_q != CNT_MAX)) ? err_q + CNT_WIDTH'(1) : err_q;
        ovf_d  = ovf_q | drop_s;
        drop_d = (drop_s && (drop_q != CNT_MAX)) ? drop_q + CNT_WIDTH'(1) : drop_q;

        we_d   = (state_q == SEND) & ~bus.FIFO_OUT_FULL;
        data_d = mem0_q[2'd3 - ptr_q];
        if (pop_s) begin
            ptr_d = 2'd0;
        end else if (we_d) begin
            ptr_d = ptr_q + 2'd1;
        end else begin
            ptr_d = ptr_q;
        end

        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (cnt_d != 2'd0) ? SEND : IDLE;
            SEND:    state_d = (cnt_d == 2'd0) ? IDLE : SEND;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset discards any codeword or nibble in flight
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            lock_q    <= 1'b0;
            bit_idx_q <= 3'd0;
            pay_idx_q <= '0;
            cw_q      <= 6'd0;
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            cnt_q     <= 2'd0;
            mem0_q    <= 4'd0;
            mem1_q    <= 4'd0;
            we_q      <= 1'b0;
            data_q    <= 1'b0;
            corr_q    <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= '0;
            drop_q    <= '0;
        end else begin
            lock_q    <= lock_d;
            bit_idx_q <= bit_idx_d;
            pay_idx_q <= pay_idx_d;
            cw_q      <= cw_d;
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            mem0_q    <= mem0_d;
            mem1_q    <= mem1_d;
            we_q      <= we_d;
            data_q    <= data_d;
            corr_q    <= corr_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.FIFO_OUT_WE   = we_q;
    assign bus.FIFO_OUT_DATA = data_q;
    assign CORR_PULSE        = corr_q;
    assign OVERFLOW          = ovf_q;
    assign ERR_COUNT         = err_q;
    assign DROP_COUNT        = drop_q;
endmodule

// File: tb/tb_hamming_deframe_decoder.sv
// Scoreboard bench for hamming_deframe_decoder: stimulus pushes expected output
// bits into a queue, a negedge monitor pops and compares on every FIFO write.
module tb_hamming_deframe_decoder;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        CORR_PULSE, OVERFLOW;
    logic [15:0] ERR_COUNT, DROP_COUNT;

    hamming_deframe_decoder_if bus();

    hamming_deframe_decoder #(.PAYLOAD_LEN(28), .CNT_WIDTH(16)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .bus        (bus.slave),
        .CORR_PULSE (CORR_PULSE),
        .OVERFLOW   (OVERFLOW),
        .ERR_COUNT  (ERR_COUNT),
        .DROP_COUNT (DROP_COUNT)
    );

    always #5 CLK = ~CLK;

    int   vectors = 0;
    int   miscompares = 0;
    logic exp_q[$];
    int   wr_cnt = 0;
    int   corr_cnt = 0;
    logic prev_full = 1'b0;
    bit   rand_full = 1'b0;
    int   since_full = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {p1,p2,d1,p3,d2,d3,d4} with c1 as MSB, from d = {d1,d2,d3,d4}
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic p1, p2, p3;
        p1 = d[3] ^ d[2] ^ d[0];
        p2 = d[3] ^ d[1] ^ d[0];
        p3 = d[2] ^ d[1] ^ d[0];
        return {p1, p2, d[3], p3, d[2], d[1], d[0]};
    endfunction

    // Monitor: compares every write against the scoreboard head
    initial begin
        forever begin
            @(negedge CLK);
            if (RESET) begin
                if (CORR_PULSE) corr_cnt++;
                if (bus.FIFO_OUT_WE) begin
                    wr_cnt++;
                    check("we_while_full", {31'd0, prev_full}, 32'd0);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_write: got data %0b expected no write", bus.FIFO_OUT_DATA);
                    end else begin
                        check("out_bit", {31'd0, bus.FIFO_OUT_DATA}, {31'd0, exp_q.pop_front()});
                    end
                end
                prev_full = bus.FIFO_OUT_FULL;
            end else begin
                prev_full = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        if (rand_full) begin
            if (since_full >= 3 && $urandom_range(0, 2) == 0) begin
                bus.FIFO_OUT_FULL = 1'b1;
                since_full = 0;
            end else begin
                bus.FIFO_OUT_FULL = 1'b0;
                since_full++;
            end
        end
        bus.DATA_IN       = b;
        bus.DATA_IN_VALID = 1'b1;
        tick();
    endtask

    // cw is c1..c7 MSB first; nib is the data expected after correction
    task automatic send_cw(input logic [6:0] cw, input logic [3:0] nib, input bit keep);
        if (keep) begin
            for (int i = 3; i >= 0; i--) exp_q.push_back(nib[i]);
        end
        for (int i = 6; i >= 0; i--) send_bit(cw[i]);
        bus.DATA_IN_VALID = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check(name, exp_q.size(), 32'd0);
        repeat (4) tick();
    endtask

    task automatic apply_reset();
        RESET = 1'b0;
        repeat (2) tick();
        exp_q.delete();
        RESET = 1'b1;
        tick();
    endtask

    initial begin
        int m;
        logic [3:0] nib;
        logic [6:0] cw;
        bit hit;

        RESET = 1'b0;
        bus.DATA_IN = 1'b0;
        bus.DATA_IN_VALID = 1'b0;
        bus.LOCK = 1'b0;
        bus.FIFO_OUT_FULL = 1'b0;
        repeat (3) tick();
        check("rst_we",   {31'd0, bus.FIFO_OUT_WE}, 32'd0);
        check("rst_data", {31'd0, bus.FIFO_OUT_DATA}, 32'd0);
        check("rst_corr", {31'd0, CORR_PULSE}, 32'd0);
        check("rst_ovf",  {31'd0, OVERFLOW}, 32'd0);
        check("rst_err",  {16'd0, ERR_COUNT}, 32'd0);
        check("rst_drop", {16'd0, DROP_COUNT}, 32'd0);
        RESET = 1'b1;
        tick();
        bus.LOCK = 1'b1;
        tick();

        // 1: clean codeword, first write two cycles after c7
        send_cw(7'b0110011, 4'b1011, 1'b1);
        @(negedge CLK);
        check("t1_we_n1", {31'd0, bus.FIFO_OUT_WE}, 32'd0);
        check("t1_corr_n1", {31'd0, CORR_PULSE}, 32'd0);
        @(negedge CLK);
        check("t1_we_n2", {31'd0, bus.FIFO_OUT_WE}, 32'd1);
        drain("t1_drain");
        check("t1_corr_cnt", corr_cnt, 32'd0);
        check("t1_err", {16'd0, ERR_COUNT}, 32'd0);

        // 2: data-bit error, then parity-bit error
        send_cw(7'b0110111, 4'b1011, 1'b1);
        @(negedge CLK);
        check("t2_corr_n1", {31'd0, CORR_PULSE}, 32'd1);
        check("t2_err1", {16'd0, ERR_COUNT}, 32'd1);
        drain("t2_drain1");
        send_cw(7'b1110011, 4'b1011, 1'b1);
        drain("t2_drain2");
        check("t2_err2", {16'd0, ERR_COUNT}, 32'd2);
        check("t2_corr_cnt", corr_cnt, 32'd2);

        // 3: FIFO full across four back-to-back codewords
        bus.FIFO_OUT_FULL = 1'b1;
        tick();
        send_cw(encode(4'h3), 4'h3, 1'b1);
        send_cw(encode(4'hC), 4'hC, 1'b1);
        send_cw(encode(4'h5), 4'h5, 1'b0);
        send_cw(encode(4'hA), 4'hA, 1'b0);
        repeat (3) tick();
        check("t3_ovf", {31'd0, OVERFLOW}, 32'd1);
        check("t3_drop", {16'd0, DROP_COUNT}, 32'd2);
        bus.FIFO_OUT_FULL = 1'b0;
        drain("t3_drain");
        check("t3_err", {16'd0, ERR_COUNT}, 32'd2);

        // 4: partial codeword discarded on loss of lock
        cw = encode(4'h9);
        for (int i = 6; i >= 4; i--) send_bit(cw[i]);
        bus.DATA_IN_VALID = 1'b0;
        bus.LOCK = 1'b0;
        tick();
        bus.LOCK = 1'b1;
        tick();
        m = wr_cnt;
        send_cw(encode(4'h6), 4'h6, 1'b1);
        send_cw(encode(4'hF) ^ 7'b0001000, 4'hF, 1'b1);
        send_cw(encode(4'h0), 4'h0, 1'b1);
        send_cw(encode(4'h8), 4'h8, 1'b1);
        drain("t4_drain");
        check("t4_writes", wr_cnt - m, 32'd16);
        check("t4_err", {16'd0, ERR_COUNT}, 32'd3);

        // 5: ten frames, one error per codeword, FULL toggling
        apply_reset();
        m = wr_cnt;
        rand_full = 1'b1;
        for (int f = 0; f < 10; f++) begin
            for (int c = 0; c < 4; c++) begin
                nib = 4'($urandom_range(0, 15));
                cw = encode(nib) ^ (7'b0000001 << $urandom_range(0, 6));
                send_cw(cw, nib, 1'b1);
            end
        end
        rand_full = 1'b0;
        bus.FIFO_OUT_FULL = 1'b0;
        drain("t5_drain");
        check("t5_writes", wr_cnt - m, 32'd160);
        check("t5_err", {16'd0, ERR_COUNT}, 32'd40);
        check("t5_ovf", {31'd0, OVERFLOW}, 32'd0);

        // 6: reset in the middle of a nibble
        m = wr_cnt + 2;
        send_cw(7'b0110111, 4'b1011, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            if (wr_cnt >= m) begin
                hit = 1'b1;
                break;
            end
        end
        check("t6_reached_d2", {31'd0, hit}, 32'd1);
        #1;
        RESET = 1'b0;
        #1;
        check("t6_we_rst", {31'd0, bus.FIFO_OUT_WE}, 32'd0);
        check("t6_err_rst", {16'd0, ERR_COUNT}, 32'd0);
        check("t6_drop_rst", {16'd0, DROP_COUNT}, 32'd0);
        check("t6_ovf_rst", {31'd0, OVERFLOW}, 32'd0);
        exp_q.delete();
        tick();
        RESET = 1'b1;
        tick();
        send_cw(encode(4'h6) ^ 7'b0000100, 4'h6, 1'b1);
        drain("t6_drain");
        check("t6_err", {16'd0, ERR_COUNT}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
